mux_pry_rr: RTL and testbench
=============================

# mux_pry_rr

Registered priority multiplexer with a valid/ready handshake and selectable fixed-priority or round-robin arbitration. It takes WIDTH request channels, each carrying a DAT_T payload, and grants one per cycle. The granted payload and its index go into a single output register. It sits between several producers sharing one downstream consumer, as the sequential successor of the combinational priority mux.

## Interface
- DAT_T, logic [8-1:0], payload type
- WIDTH, 32, number of request channels (any value ≥ 2, not restricted to a power of SPLIT)
- SPLIT, 2, radix of the internal priority-select tree
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- IDX_W, $clog2(WIDTH), width of the index output (localparam)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_vld  in  WIDTH  per-channel request valid
- req_ary  in  DAT_T [WIDTH-1:0]  per-channel payload
- req_lst  in  WIDTH  per-channel last-beat flag (used only with lock feature)
- req_rdy  out  WIDTH  per-channel accept, at most one bit set
- out_vld  out  1  output register valid
- out_dat  out  DAT_T  output payload
- out_idx  out  IDX_W  index of the channel that supplied out_dat
- out_lst  out  1  registered req_lst of the granted beat
- out_rdy  in  1  downstream ready

## Operation
- Output register holds one beat. acc = !out_vld || out_rdy.
- Grant vector gnt is one-hot. It is computed combinationally from req_vld and the priority pointer ptr.
- req_rdy = gnt & {WIDTH{acc}}. A transfer on channel i occurs when req_vld[i] && req_rdy[i].
- On a transfer, out_dat, out_idx and out_lst are loaded from channel i, and out_vld is set to 1.
- On acc with no request valid, out_vld is cleared to 0. out_dat, out_idx and out_lst hold their values when not loaded.
- MODE 0: ptr is constant 0, and the lowest set index of req_vld wins.
- MODE 1: the search starts at ptr and wraps modulo WIDTH. After a transfer on channel i, ptr = (i+1) mod WIDTH; the wrap from WIDTH-1 goes to 0. ptr is unchanged when there is no transfer.
- The selection tree is padded to SPLIT**ceil(log_SPLIT(WIDTH)). Padded positions never request.
- Producers must hold req_vld and req_ary stable until req_rdy. req_rdy may depend combinationally on req_vld and out_rdy.
- No request is ever dropped. In MODE 1, a continuously asserted request is granted within WIDTH transfers.

## Timing
- Latency: 1 cycle from the transfer edge to out_vld / out_dat.
- Throughput: 1 beat per cycle while out_rdy = 1.
- Backpressure: when out_vld && !out_rdy, req_rdy = 0, and the output register and ptr hold.
- Simultaneous events: a downstream pop (out_rdy) and an upstream load in the same cycle produce back-to-back beats with no bubble.
- Reset values: out_vld = 0, out_dat = 0, out_idx = 0, out_lst = 0, ptr = 0, lock state = unlocked.
- req_rdy is combinationally 0 while rst = 1.
- rst mid-packet or mid-backpressure discards the held beat, and the next grant restarts from ptr = 0.

## Configuration
- Macro MUX_PRY_RR_LOCK_EN enables packet locking.
- Defined:
  - A transfer with req_lst = 0 locks arbitration to that channel.
  - While locked, gnt is forced to the locked index, whether or not the channel is valid; other channels see req_rdy = 0.
  - The lock releases after the transfer that carries req_lst = 1.
  - In MODE 1, ptr updates only on that releasing transfer.
- Undefined:
  - req_lst is ignored for arbitration, and every beat is arbitrated independently.
  - out_lst still forwards the granted req_lst.

## Test plan
- Reset then idle: rst high 3 cycles, then req_vld = 0 → out_vld = 0, out_dat = 0, out_idx = 0, req_rdy = 0 every cycle.
- MODE 0, WIDTH = 5 (non-power padding), req_vld = 5'b10110 held, out_rdy = 1 → out_idx sequence 1,1,1…, with req_ary[1] appearing one cycle after each grant.
- MODE 1, WIDTH = 4, all four requests held, out_rdy = 1 → out_idx 0,1,2,3,0,1 on consecutive cycles; ptr wraps from 3 to 0.
- Backpressure: out_vld = 1 with payload 8'hA5, out_rdy = 0 for 4 cycles, new requests present → out_dat stays 8'hA5, req_rdy = 0, and ptr is unchanged. When out_rdy rises, the next beat appears the following cycle with no bubble.
- MUX_PRY_RR_LOCK_EN, MODE 1: channel 2 sends 3 beats with lst = 0,0,1 while channel 0 requests → out_idx = 2,2,2, then 0; channel 0's req_rdy stays 0 during the packet.
- rst asserted for one cycle while out_vld = 1 and locked → the next cycle shows out_vld = 0 and the lock is cleared. The following grant uses ptr = 0.

Source files
------------

// File: rtl/mux_pry_rr.sv
// mux_pry_rr: registered WIDTH:1 arbiter/mux, fixed-priority (MODE 0) or round-robin (MODE 1).
// Latency: 1 cycle from transfer edge to out_vld/out_dat; throughput 1 beat/cycle.
// Backpressure: req_rdy = 0 while out_vld && !out_rdy or while rst; output reg and ptr hold.
// Ports: clk, rst (sync, active-high); per channel req_vld/req_ary/req_lst in, req_rdy out;
//        out_vld/out_dat/out_idx/out_lst out, out_rdy in.
// Option: define MUX_PRY_RR_LOCK_EN to lock arbitration to a channel until its req_lst beat.
module mux_pry_rr #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 32,
  parameter int  SPLIT = 2,
  parameter int  MODE  = 0,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  req_vld,
  input  DAT_T [WIDTH-1:0]  req_ary,
  input  logic [WIDTH-1:0]  req_lst,
  output logic [WIDTH-1:0]  req_rdy,
  output logic              out_vld,
  output DAT_T              out_dat,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_lst,
  input  logic              out_rdy
);

  // Depth of the SPLIT-ary selection tree covering WIDTH leaves.
  function automatic int tree_lvls(input int w, input int s);
    int n;
    int l;
    n = 1;
    l = 0;
    while (n < w) begin
      n = n * s;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int LVLS = tree_lvls(WIDTH, SPLIT);
  localparam int NPAD = SPLIT ** LVLS;
  localparam int PW   = $clog2(NPAD);

  logic             out_vld_q, out_vld_d;
  DAT_T             out_dat_q, out_dat_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_lst_q, out_lst_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

`ifdef MUX_PRY_RR_LOCK_EN
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
`endif

  logic [WIDTH-1:0] rot_req;
  logic             node_vld [LVLS+1][NPAD];
  logic [PW-1:0]    node_pos [LVLS+1][NPAD];
  logic             sel_vld;
  logic [IDX_W:0]   sel_sum;
  logic [IDX_W-1:0] sel_idx;
  logic             acc;
  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt;
  logic             xfer;
  logic [IDX_W-1:0] ptr_nxt;

  // Rotate requests so position 0 is the channel at ptr; the tree then only
  // has to find the lowest set position. In MODE 0 ptr stays 0.
  always_comb begin
    logic [IDX_W:0] k;
    for (int j = 0; j < WIDTH; j++) begin
      k = (IDX_W+1)'(j) + {1'b0, ptr_q};
      if (k >= (IDX_W+1)'(WIDTH)) k = k - (IDX_W+1)'(WIDTH);
      rot_req[j] = req_vld[k[IDX_W-1:0]];
    end
  end

  // Priority tree: each node keeps the lowest-positioned valid child.
  // Leaves at WIDTH..NPAD-1 are padding and stay invalid.
  always_comb begin
    int cnt;
    int k;
    for (int l = 0; l <= LVLS; l++) begin
      for (int n = 0; n < NPAD; n++) begin
        node_vld[l][n] = 1'b0;
        node_pos[l][n] = '0;
      end
    end
    for (int n = 0; n < WIDTH; n++) begin
      node_vld[0][n] = rot_req[n];
      node_pos[0][n] = PW'(n);
    end
    cnt = NPAD;
    for (int l = 1; l <= LVLS; l++) begin
      cnt = cnt / SPLIT;
      for (int n = 0; n < NPAD / SPLIT; n++) begin
        if (n < cnt) begin
          for (int c = SPLIT - 1; c >= 0; c--) begin
            k = n * SPLIT + c;
            if (node_vld[l-1][k]) begin
              node_vld[l][n] = 1'b1;
              node_pos[l][n] = node_pos[l-1][k];
            end
          end
        end
      end
    end
    sel_vld = node_vld[LVLS][0];
    // Undo the rotation: position + ptr, modulo WIDTH.
    sel_sum = (IDX_W+1)'(node_pos[LVLS][0]) + {1'b0, ptr_q};
    if (sel_sum >= (IDX_W+1)'(WIDTH)) sel_sum = sel_sum - (IDX_W+1)'(WIDTH);
    sel_idx = sel_sum[IDX_W-1:0];
  end

  always_comb begin
    acc     = (!out_vld_q || out_rdy) && !rst;
    gnt_any = sel_vld;
    gnt_idx = sel_idx;
`ifdef MUX_PRY_RR_LOCK_EN
    // A locked channel owns the grant even while it has no valid beat.
    if (lock_q) begin
      gnt_any = 1'b1;
      gnt_idx = lock_idx_q;
    end
`endif
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    req_rdy = acc ? gnt : '0;
    xfer    = acc && gnt_any && req_vld[gnt_idx];
    ptr_nxt = (gnt_idx == IDX_W'(WIDTH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_idx_d = out_idx_q;
    out_lst_d = out_lst_q;
    ptr_d     = ptr_q;
    if (acc) begin
      out_vld_d = xfer;
      if (xfer) begin
        out_dat_d = req_ary[gnt_idx];
        out_idx_d = gnt_idx;
        out_lst_d = req_lst[gnt_idx];
      end
    end
`ifdef MUX_PRY_RR_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (xfer) begin
      lock_d     = !req_lst[gnt_idx];
      lock_idx_d = gnt_idx;
    end
    // Pointer moves only when a packet completes.
    if (MODE == 1 && xfer && req_lst[gnt_idx]) ptr_d = ptr_nxt;
`else
    if (MODE == 1 && xfer) ptr_d = ptr_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_idx_q  <= '0;
      out_lst_q  <= 1'b0;
      ptr_q      <= '0;
`ifdef MUX_PRY_RR_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_idx_q  <= out_idx_d;
      out_lst_q  <= out_lst_d;
      ptr_q      <= ptr_d;
`ifdef MUX_PRY_RR_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign out_idx = out_idx_q;
  assign out_lst = out_lst_q;

endmodule

// File: tb/tb_mux_pry_rr.sv
module tb_mux_pry_rr;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Fixed-priority instance, WIDTH 5 (padded tree), radix 2.
  logic [4:0] fp_vld, fp_lst, fp_rdy;
  logic [4:0][7:0] fp_ary;
  logic fp_ovld, fp_olst, fp_ordy;
  logic [7:0] fp_odat;
  logic [2:0] fp_oidx;
  // Round-robin instance, WIDTH 4, radix 3 (padded to 9).
  logic [3:0] rr_vld, rr_lst, rr_rdy;
  logic [3:0][7:0] rr_ary;
  logic rr_ovld, rr_olst, rr_ordy;
  logic [7:0] rr_odat;
  logic [1:0] rr_oidx;

  mux_pry_rr #(.WIDTH(5), .SPLIT(2), .MODE(0)) u_fp (
    .clk(clk), .rst(rst), .req_vld(fp_vld), .req_ary(fp_ary), .req_lst(fp_lst),
    .req_rdy(fp_rdy), .out_vld(fp_ovld), .out_dat(fp_odat), .out_idx(fp_oidx),
    .out_lst(fp_olst), .out_rdy(fp_ordy));

  mux_pry_rr #(.WIDTH(4), .SPLIT(3), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req_vld(rr_vld), .req_ary(rr_ary), .req_lst(rr_lst),
    .req_rdy(rr_rdy), .out_vld(rr_ovld), .out_dat(rr_odat), .out_idx(rr_oidx),
    .out_lst(rr_olst), .out_rdy(rr_ordy));

  typedef struct { int idx; logic [7:0] dat; logic lst; } beat_t;
  beat_t fp_q[$];
  beat_t rr_q[$];
  bit fp_mvld, rr_mvld, rr_lock;
  int rr_ptr, rr_lidx;
  logic [4:0] fp_exp_rdy, fp_act_rdy;
  logic [3:0] rr_exp_rdy, rr_act_rdy;
  int n_tests = 0;
  int n_fail = 0;

  function automatic int pick(input logic [4:0] v, input int w, input int p);
    int c;
    for (int k = 0; k < w; k++) begin
      c = (p + k) % w;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock: sample req_rdy before the edge, advance the reference model
  // (pushing expected beats), return at the following falling edge.
  task automatic tick();
    int fg, rg;
    bit facc, racc, fx, rx;
    #1;
    facc = (!fp_mvld || fp_ordy) && !rst;
    fg = pick(fp_vld, 5, 0);
    fx = facc && (fg >= 0);
    fp_exp_rdy = fx ? 5'(1 << fg) : 5'd0;
    fp_act_rdy = fp_rdy;
    racc = (!rr_mvld || rr_ordy) && !rst;
    rg = rr_lock ? rr_lidx : pick({1'b0, rr_vld}, 4, rr_ptr);
    rr_exp_rdy = (racc && rg >= 0) ? 4'(1 << rg) : 4'd0;
    rx = racc && (rg >= 0) && rr_vld[rg];
    rr_act_rdy = rr_rdy;
    @(posedge clk);
    if (rst) begin
      fp_q.delete(); rr_q.delete();
      fp_mvld = 0; rr_mvld = 0; rr_ptr = 0; rr_lock = 0;
    end else begin
      if (facc) begin
        if (fp_mvld) void'(fp_q.pop_front());
        if (fx) fp_q.push_back('{fg, fp_ary[fg], fp_lst[fg]});
        fp_mvld = fx;
      end
      if (racc) begin
        if (rr_mvld) void'(rr_q.pop_front());
        if (rx) begin
          rr_q.push_back('{rg, rr_ary[rg], rr_lst[rg]});
`ifdef MUX_PRY_RR_LOCK_EN
          rr_lock = !rr_lst[rg];
          rr_lidx = rg;
          if (rr_lst[rg]) rr_ptr = (rg + 1) % 4;
`else
          rr_ptr = (rg + 1) % 4;
`endif
        end
        rr_mvld = rx;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; fp_vld = '1; rr_vld = '1; fp_ordy = 1; rr_ordy = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (fp_act_rdy !== 5'd0 || rr_act_rdy !== 4'd0) begin
        n_fail++; $display("FAIL reset_rdy: fp %b rr %b, need 0", fp_act_rdy, rr_act_rdy);
      end
      n_tests++;
      if ({fp_ovld, fp_odat, fp_oidx, fp_olst} !== 13'd0 || {rr_ovld, rr_odat, rr_oidx, rr_olst} !== 12'd0) begin
        n_fail++; $display("FAIL reset_out: fp %b/%h/%0d/%b rr %b/%h/%0d/%b, need all 0",
                           fp_ovld, fp_odat, fp_oidx, fp_olst, rr_ovld, rr_odat, rr_oidx, rr_olst);
      end
    end
    rst = 0; fp_vld = '0; rr_vld = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (fp_act_rdy !== 5'd0 || rr_act_rdy !== 4'd0 || fp_ovld !== 1'b0 || rr_ovld !== 1'b0) begin
        n_fail++; $display("FAIL idle: rdy %b/%b vld %b/%b, need 0", fp_act_rdy, rr_act_rdy, fp_ovld, rr_ovld);
      end
    end
  endtask

  task automatic test_fixed_pri();
    logic [4:0] pats [5] = '{5'b10110, 5'b10000, 5'b01100, 5'b11111, 5'b00000};
    int win [5] = '{1, 4, 2, 0, -1};
    fp_ordy = 1; fp_lst = 5'b01010;
    for (int p = 0; p < 5; p++) begin
      fp_vld = pats[p];
      for (int i = 0; i < 5; i++) fp_ary[i] = 8'(16 * p + i + 8'h40);
      for (int c = 0; c < 3; c++) begin
        tick();
        n_tests++;
        if (fp_act_rdy !== fp_exp_rdy) begin
          n_fail++; $display("FAIL fp_rdy p%0d: got %b need %b", p, fp_act_rdy, fp_exp_rdy);
        end
        n_tests++;
        if (fp_ovld !== fp_mvld) begin
          n_fail++; $display("FAIL fp_vld p%0d: got %b need %b", p, fp_ovld, fp_mvld);
        end else if (fp_mvld) begin
          n_tests++;
          if (fp_odat !== fp_q[0].dat || fp_oidx !== 3'(fp_q[0].idx) || fp_olst !== fp_q[0].lst) begin
            n_fail++; $display("FAIL fp_beat p%0d: got %h/%0d/%b need %h/%0d/%b", p, fp_odat, fp_oidx,
                               fp_olst, fp_q[0].dat, fp_q[0].idx, fp_q[0].lst);
          end
        end
        if (win[p] >= 0) begin
          n_tests++;
          if (fp_oidx !== 3'(win[p]) || fp_odat !== fp_ary[win[p]]) begin
            n_fail++; $display("FAIL fp_lowest p%0d: idx %0d dat %h need %0d", p, fp_oidx, fp_odat, win[p]);
          end
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    rr_ordy = 1; rr_lst = '1; rr_vld = 4'b1111;
    for (int i = 0; i < 4; i++) rr_ary[i] = 8'(8'h80 + i);
    for (int c = 0; c < 10; c++) begin
      if (c == 6) rr_vld = 4'b1010;
      tick();
      n_tests++;
      if (rr_act_rdy !== rr_exp_rdy) begin
        n_fail++; $display("FAIL rr_rdy c%0d: got %b need %b", c, rr_act_rdy, rr_exp_rdy);
      end
      n_tests++;
      if (rr_ovld !== 1'b1 || rr_odat !== rr_q[0].dat || rr_oidx !== 2'(rr_q[0].idx)) begin
        n_fail++; $display("FAIL rr_beat c%0d: got %b/%h/%0d need 1/%h/%0d", c, rr_ovld, rr_odat,
                           rr_oidx, rr_q[0].dat, rr_q[0].idx);
      end
      if (c < 6) begin
        n_tests++;
        if (rr_oidx !== 2'(seq[c])) begin
          n_fail++; $display("FAIL rr_order c%0d: got %0d need %0d", c, rr_oidx, seq[c]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rr_ordy = 1; rr_vld = 4'b0001; rr_ary = {8'hB3, 8'hB2, 8'hB1, 8'hA5};
    tick();
    n_tests++;
    if (rr_ovld !== 1'b1 || rr_odat !== 8'hA5) begin
      n_fail++; $display("FAIL bp_load: got %b/%h need 1/a5", rr_ovld, rr_odat);
    end
    rr_ordy = 0; rr_vld = 4'b1110;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (rr_act_rdy !== 4'd0 || rr_ovld !== 1'b1 || rr_odat !== 8'hA5) begin
        n_fail++; $display("FAIL bp_hold c%0d: rdy %b vld %b dat %h need 0/1/a5", c, rr_act_rdy, rr_ovld, rr_odat);
      end
    end
    rr_ordy = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (rr_ovld !== 1'b1 || rr_oidx !== 2'(c + 1) || rr_odat !== rr_ary[c + 1]) begin
        n_fail++; $display("FAIL bp_release c%0d: got %b/%0d/%h need 1/%0d/%h", c, rr_ovld, rr_oidx,
                           rr_odat, c + 1, rr_ary[c + 1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    rr_ordy = 1; rr_lst = '1; rr_vld = 4'b0100;
    tick();
    rr_ordy = 0; rr_vld = 4'b1010;
    tick();
    rst = 1;
    tick();
    rst = 0;
    n_tests++;
    if (rr_ovld !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_vld: got %b need 0", rr_ovld);
    end
    rr_ordy = 1;
    tick();
    n_tests++;
    if (rr_ovld !== 1'b1 || rr_oidx !== 2'd1) begin
      n_fail++; $display("FAIL rst_mid_ptr: got %b/%0d need 1/1", rr_ovld, rr_oidx);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 80; c++) begin
      fp_vld = 5'($urandom); fp_lst = 5'($urandom); fp_ary = 40'({$urandom, $urandom});
      rr_vld = 4'($urandom); rr_lst = 4'($urandom); rr_ary = $urandom;
      fp_ordy = 1'($urandom_range(0, 3) != 0); rr_ordy = 1'($urandom_range(0, 3) != 0);
      tick();
      n_tests++;
      if (fp_act_rdy !== fp_exp_rdy || rr_act_rdy !== rr_exp_rdy) begin
        n_fail++; $display("FAIL rnd_rdy c%0d: fp %b/%b rr %b/%b", c, fp_act_rdy, fp_exp_rdy, rr_act_rdy, rr_exp_rdy);
      end
      n_tests++;
      if (fp_ovld !== fp_mvld || (fp_mvld && (fp_odat !== fp_q[0].dat || fp_oidx !== 3'(fp_q[0].idx)
          || fp_olst !== fp_q[0].lst))) begin
        n_fail++; $display("FAIL rnd_fp c%0d: got %b/%h/%0d need %b", c, fp_ovld, fp_odat, fp_oidx, fp_mvld);
      end
      n_tests++;
      if (rr_ovld !== rr_mvld || (rr_mvld && (rr_odat !== rr_q[0].dat || rr_oidx !== 2'(rr_q[0].idx)
          || rr_olst !== rr_q[0].lst))) begin
        n_fail++; $display("FAIL rnd_rr c%0d: got %b/%h/%0d need %b", c, rr_ovld, rr_odat, rr_oidx, rr_mvld);
      end
    end
  endtask

`ifdef MUX_PRY_RR_LOCK_EN
  task automatic test_lock();
    int exp_idx [4] = '{2, 2, 2, 0};
    logic [3:0] vseq [4] = '{4'b0100, 4'b0101, 4'b0101, 4'b0001};
    logic [3:0] lseq [4] = '{4'b0000, 4'b0000, 4'b0100, 4'b0001};
    rst = 1; tick(); rst = 0;
    rr_ordy = 1;
    for (int c = 0; c < 4; c++) begin
      rr_vld = vseq[c]; rr_lst = lseq[c];
      rr_ary = {8'hD3, 8'(8'hC0 + c), 8'hD1, 8'hD0};
      tick();
      n_tests++;
      if (rr_ovld !== 1'b1 || rr_oidx !== 2'(exp_idx[c])) begin
        n_fail++; $display("FAIL lock_seq c%0d: got %b/%0d need 1/%0d", c, rr_ovld, rr_oidx, exp_idx[c]);
      end
      if (c < 3) begin
        n_tests++;
        if (rr_act_rdy[0] !== 1'b0) begin
          n_fail++; $display("FAIL lock_block c%0d: ch0 rdy %b need 0", c, rr_act_rdy[0]);
        end
      end
    end
    rr_vld = 4'b0100; rr_lst = 4'b0000;
    tick();
    rst = 1;
    tick();
    rst = 0;
    n_tests++;
    if (rr_ovld !== 1'b0) begin
      n_fail++; $display("FAIL lock_rst_vld: got %b need 0", rr_ovld);
    end
    rr_vld = 4'b1010; rr_lst = 4'b1111;
    tick();
    n_tests++;
    if (rr_ovld !== 1'b1 || rr_oidx !== 2'd1) begin
      n_fail++; $display("FAIL lock_rst_clear: got %b/%0d need 1/1", rr_ovld, rr_oidx);
    end
  endtask
`endif

  initial begin
    rst = 1; fp_vld = '0; fp_lst = '0; fp_ary = '0; fp_ordy = 1;
    rr_vld = '0; rr_lst = '0; rr_ary = '0; rr_ordy = 1;
    fp_mvld = 0; rr_mvld = 0; rr_lock = 0; rr_ptr = 0; rr_lidx = 0;
    test_reset();
    test_fixed_pri();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef MUX_PRY_RR_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
